// File: rtl/accel_dispatcher_trace.sv
// Run-time loadable multi-pass trace dispatcher for the Ara request port.
// Optional result checking: define ACCEL_DISPATCHER_RESULT_CHECK_EN.
module accel_dispatcher_trace #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned Depth          = 256,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned LoopWidth      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
  input  logic [31:0]          load_insn_i,
  input  logic [XLEN-1:0]      load_rs1_i,
  input  logic [XLEN-1:0]      load_rs2_i,
  input  logic                 load_wb_i,
  input  logic [XLEN-1:0]      load_exp_i,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [LoopWidth-1:0] loop_cnt_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [31:0]          req_insn_o,
  output logic [XLEN-1:0]      req_rs1_o,
  output logic [XLEN-1:0]      req_rs2_o,
  input  logic                 resp_valid_i,
  output logic                 resp_ready_o,
  input  logic [XLEN-1:0]      resp_result_i,
  input  logic                 acc_idle_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [63:0]          cycles_o,
  output logic [31:0]          dispatched_o,
  output logic [31:0]          stalls_o,
  output logic [15:0]          mismatch_cnt_o,
  output logic                 protocol_err_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e r_state;
  state_e w_next;

  logic [31:0]     r_mem_insn [Depth];
  logic [XLEN-1:0] r_mem_rs1  [Depth];
  logic [XLEN-1:0] r_mem_rs2  [Depth];
  logic            r_mem_wb   [Depth];

  logic [CW-1:0]        r_count;
  logic [AW-1:0]        r_rd_ptr;
  logic [LoopWidth-1:0] r_passes;
  logic [OW-1:0]        r_out;
  logic                 r_perr;
  logic [63:0]          r_cycles;
  logic [31:0]          r_disp;
  logic [31:0]          r_stalls;

  logic          w_busy;
  logic          w_load_hs;
  logic          w_req_hs;
  logic          w_stall;
  logic [CW-1:0] w_cnt_m1;
  logic          w_last;
  logic          w_wb_disp;
  logic          w_resp_ok;
  logic          w_start_go;

  assign w_busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_load_hs  = load_valid_i & load_ready_o;
  assign w_req_hs   = req_valid_o & req_ready_i;
  assign w_stall    = req_valid_o & ~req_ready_i;
  assign w_cnt_m1   = r_count - CW'(1);
  assign w_last     = (r_rd_ptr == w_cnt_m1[AW-1:0]);
  assign w_wb_disp  = w_req_hs & r_mem_wb[r_rd_ptr];
  assign w_resp_ok  = resp_valid_i & (r_out != '0);
  assign w_start_go = ((r_state == S_IDLE) || (r_state == S_DONE))
                    & start_i & ~clear_i;

  assign load_ready_o   = (r_state == S_IDLE) && (r_count < CW'(Depth));
  assign req_valid_o    = (r_state == S_RUN) && (r_out < OW'(MaxOutstanding));
  assign req_insn_o     = r_mem_insn[r_rd_ptr];
  assign req_rs1_o      = r_mem_rs1[r_rd_ptr];
  assign req_rs2_o      = r_mem_rs2[r_rd_ptr];
  assign resp_ready_o   = 1'b1;
  assign busy_o         = w_busy;
  assign done_o         = (r_state == S_DONE);
  assign cycles_o       = r_cycles;
  assign dispatched_o   = r_disp;
  assign stalls_o       = r_stalls;
  assign protocol_err_o = r_perr;

  // Trace storage: no reset, contents survive clear
  always_ff @(posedge clk_i) begin
    if (w_load_hs) begin
      r_mem_insn[r_count[AW-1:0]] <= load_insn_i;
      r_mem_rs1[r_count[AW-1:0]]  <= load_rs1_i;
      r_mem_rs2[r_count[AW-1:0]]  <= load_rs2_i;
      r_mem_wb[r_count[AW-1:0]]   <= load_wb_i;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; clear always wins
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (clear_i)      w_next = S_IDLE;
        else if (start_i) w_next = (r_count != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (clear_i)
          w_next = S_IDLE;
        else if (w_req_hs && w_last && (r_passes == '0))
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (clear_i)
          w_next = S_IDLE;
        else if ((r_out == '0) && acc_idle_i)
          w_next = S_DONE;
      end
      S_DONE: begin
        if (clear_i)      w_next = S_IDLE;
        else if (start_i) w_next = (r_count != '0) ? S_RUN : S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Trace length, read pointer and pass counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_passes <= '0;
    end else if (clear_i) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
    end else if (w_start_go) begin
      r_rd_ptr <= '0;
      r_passes <= loop_cnt_i;
    end else begin
      if (w_load_hs) r_count <= r_count + CW'(1);
      if (w_req_hs) begin
        if (w_last) begin
          r_rd_ptr <= '0;
          if (r_passes != '0) r_passes <= r_passes - LoopWidth'(1);
        end else begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
    end
  end

  // Write-back credits and sticky protocol error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out  <= '0;
      r_perr <= 1'b0;
    end else begin
      if (resp_valid_i && (r_out == '0)) r_perr <= 1'b1;
      if (clear_i) begin
        r_out <= '0;
      end else begin
        unique case ({w_wb_disp, w_resp_ok})
          2'b10:   r_out <= r_out + OW'(1);
          2'b01:   r_out <= r_out - OW'(1);
          default: r_out <= r_out;
        endcase
      end
    end
  end

  // Saturating performance counters, cleared on each start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycles <= '0;
      r_disp   <= '0;
      r_stalls <= '0;
    end else if (w_start_go) begin
      r_cycles <= '0;
      r_disp   <= '0;
      r_stalls <= '0;
    end else begin
      if (w_busy && (r_cycles != '1))  r_cycles <= r_cycles + 64'd1;
      if (w_req_hs && (r_disp != '1))  r_disp   <= r_disp + 32'd1;
      if (w_stall && (r_stalls != '1)) r_stalls <= r_stalls + 32'd1;
    end
  end

`ifdef ACCEL_DISPATCHER_RESULT_CHECK_EN
  localparam int unsigned PW =
    (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [XLEN-1:0] r_mem_exp [Depth];
  logic [XLEN-1:0] r_fifo    [MaxOutstanding];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [15:0]     r_mis;

  assign mismatch_cnt_o = r_mis;

  // Expected-result storage alongside the trace
  always_ff @(posedge clk_i) begin
    if (w_load_hs) r_mem_exp[r_count[AW-1:0]] <= load_exp_i;
  end

  // In-order FIFO data for in-flight write-backs
  always_ff @(posedge clk_i) begin
    if (w_wb_disp && !clear_i) r_fifo[r_wp] <= r_mem_exp[r_rd_ptr];
  end

  // FIFO pointers and mismatch counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_mis <= '0;
    end else if (clear_i) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wb_disp)
        r_wp <= (r_wp == PW'(MaxOutstanding - 1)) ? '0 : r_wp + PW'(1);
      if (w_resp_ok) begin
        r_rp <= (r_rp == PW'(MaxOutstanding - 1)) ? '0 : r_rp + PW'(1);
        if ((r_fifo[r_rp] != resp_result_i) && (r_mis != '1))
          r_mis <= r_mis + 16'd1;
      end
    end
  end
`else
  logic w_unused;

  assign mismatch_cnt_o = '0;
  assign w_unused       = ^{load_exp_i, resp_result_i};
`endif

endmodule
